// File: rtl/issue_seq_pkg.sv
// Shared constants for the instruction issue sequencer: FSM encodings,
// host byte order and the compute-unit opcode map.
package issue_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // The opcode/target byte arrives first on the host stream.
    localparam bit HIGH_BYTE_FIRST = 1'b1;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LOAD = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_NOT  = 4'd6,
        OP_XOR  = 4'd7
    } opcode_e;

    function automatic logic [15:0] pack_instr(input logic [7:0] first_byte,
                                               input logic [7:0] second_byte);
        return HIGH_BYTE_FIRST ? {first_byte, second_byte} : {second_byte, first_byte};
    endfunction

endpackage

// File: rtl/instr_issue_sequencer_fifo.sv
// Show-ahead byte FIFO holding compute-unit results until the host drains them.
module byte_fifo
    import issue_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign valid    = (count != '0);
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && valid;
    assign do_push  = push && ((count != DEPTH_C) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_issue_sequencer.sv
// Loads a program from a host byte stream, replays it back-to-back to the
// compute unit and collects the returned results into a host-drained FIFO.
module instr_issue_sequencer
    import issue_seq_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int RESULT_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      host_valid,
    input  logic [7:0]                host_data,
    output logic                      host_ready,
    input  logic                      start,
    input  logic                      clear,
    output logic [15:0]               instr_out,
    output logic                      instr_ena,
    input  logic [7:0]                result_in,
    output logic                      res_valid,
    output logic [7:0]                res_data,
    input  logic                      res_ready,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(DEPTH):0]    prog_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t                    state;
    logic [CW-1:0]             issue_idx;
    logic                      have_hi;
    logic [7:0]                hi_byte;
    logic [15:0]               prog_mem [DEPTH];
    logic [RESULT_LATENCY-1:0] vld_p;

    logic byte_acc;
    logic start_ok;
    logic start_run;
    logic start_empty;
    logic prog_wr;
    logic fifo_push;

    assign host_ready  = (state == ST_IDLE) && (prog_count < DEPTH_C) && !rst;
    assign byte_acc    = host_valid && host_ready;
    assign start_ok    = (state == ST_IDLE) && start && !clear && !res_valid;
    assign start_run   = start_ok && (prog_count != '0);
    assign start_empty = start_ok && (prog_count == '0);
    // A run start wins over a byte landing in the same cycle.
    assign prog_wr     = byte_acc && have_hi && !clear && !start_run;
    assign busy        = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign fifo_push   = vld_p[RESULT_LATENCY-1] && !clear;

    always_ff @(posedge clk) begin
        if (byte_acc && !have_hi) begin
            hi_byte <= host_data;
        end
        if (prog_wr) begin
            prog_mem[prog_count[AW-1:0]] <= pack_instr(hi_byte, host_data);
        end
    end

    // Result-capture pipe: one flag per instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else if (clear) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= instr_ena;
            for (int i = 1; i < RESULT_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            issue_idx  <= '0;
            have_hi    <= 1'b0;
            prog_count <= '0;
            instr_out  <= '0;
            instr_ena  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state      <= ST_IDLE;
                issue_idx  <= '0;
                have_hi    <= 1'b0;
                prog_count <= '0;
                instr_out  <= '0;
                instr_ena  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_run) begin
                            state     <= ST_ISSUE;
                            instr_out <= prog_mem[0];
                            instr_ena <= 1'b1;
                            issue_idx <= CW'(1);
                            have_hi   <= 1'b0;
                        end else begin
                            if (start_empty) done <= 1'b1;
                            if (byte_acc) begin
                                have_hi <= !have_hi;
                                if (have_hi) prog_count <= prog_count + 1'b1;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (issue_idx == prog_count) begin
                            state     <= ST_DRAIN;
                            instr_out <= '0;
                            instr_ena <= 1'b0;
                        end else begin
                            instr_out <= prog_mem[issue_idx[AW-1:0]];
                            instr_ena <= 1'b1;
                            issue_idx <= issue_idx + 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (vld_p == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_result_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .push     (fifo_push),
        .push_data(result_in),
        .pop      (res_ready),
        .pop_data (res_data),
        .valid    (res_valid)
    );

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Bench for instr_issue_sequencer with a latency-2 compute-unit model and a
// result scoreboard.
module tb_instr_issue_sequencer;
    import issue_seq_pkg::*;

    localparam int DEPTH = 8;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_valid;
    logic [7:0]  host_data;
    logic        host_ready;
    logic        start;
    logic        clear;
    logic [15:0] instr_out;
    logic        instr_ena;
    logic [7:0]  result_in;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ready;
    logic        busy;
    logic        done;
    logic [3:0]  prog_count;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int d0;

    logic [7:0]  exp_q [$];
    logic [15:0] prog [$];

    always #5 clk = ~clk;

    instr_issue_sequencer #(.DEPTH(DEPTH), .RESULT_LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .host_valid(host_valid),
        .host_data (host_data),
        .host_ready(host_ready),
        .start     (start),
        .clear     (clear),
        .instr_out (instr_out),
        .instr_ena (instr_ena),
        .result_in (result_in),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done),
        .prog_count(prog_count)
    );

    function automatic logic [7:0] alu(input logic [15:0] ins, input logic [7:0] ra,
                                       input logic [7:0] rb);
        case (ins[15:12])
            OP_LOAD: return ins[7:0];
            OP_ADD:  return ra + rb;
            OP_SUB:  return ra - rb;
            OP_AND:  return ra & rb;
            OP_OR:   return ra | rb;
            OP_NOT:  return ~ra;
            OP_XOR:  return ra ^ rb;
            default: return 8'h00;
        endcase
    endfunction

    // Compute unit: ui_in = {op, dst}, uio_in = {srcA, srcB}; result two cycles later.
    logic [7:0] cu_regs [16];
    logic [7:0] cu_p0, cu_p1;
    assign result_in = cu_p1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cu_p0 <= 8'h00;
            cu_p1 <= 8'h00;
            for (int i = 0; i < 16; i++) cu_regs[i] <= 8'h00;
        end else begin
            cu_p1 <= cu_p0;
            if (instr_ena) begin
                cu_p0 <= alu(instr_out, cu_regs[instr_out[7:4]], cu_regs[instr_out[3:0]]);
                if (instr_out[15:12] inside {[4'd1:4'd7]})
                    cu_regs[instr_out[11:8]] <= alu(instr_out, cu_regs[instr_out[7:4]],
                                                    cu_regs[instr_out[3:0]]);
            end else begin
                cu_p0 <= 8'h00;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) check("res_extra", 32'(res_data), 32'hFFFF_FFFF);
            else check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] w);
        host_valid = 1'b1;
        host_data  = w[15:8];
        step();
        host_data  = w[7:0];
        step();
        host_valid = 1'b0;
    endtask

    task automatic load_prog();
        foreach (prog[k]) load_word(prog[k]);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic ref_push(input int n);
        logic [7:0] regs [16];
        logic [7:0] v;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        for (int k = 0; k < n; k++) begin
            v = alu(prog[k], regs[prog[k][7:4]], regs[prog[k][3:0]]);
            exp_q.push_back(v);
            if (prog[k][15:12] inside {[4'd1:4'd7]}) regs[prog[k][11:8]] = v;
        end
    endtask

    task automatic run_check(input int n);
        int dstart;
        dstart = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            check("issue_ena", 32'(instr_ena), 32'd1);
            check("issue_instr", 32'(instr_out), 32'(prog[k]));
            step();
        end
        check("issue_ena_off", 32'(instr_ena), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        repeat (LAT) step();
        check("done_early", 32'(done), 32'd0);
        step();
        check("done", 32'(done), 32'd1);
        step();
        check("done_pulse", 32'(done), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("done_count", 32'(done_cnt - dstart), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        host_valid = 1'b0;
        host_data  = 8'h00;
        start = 1'b0;
        clear = 1'b0;
        res_ready = 1'b1;
        repeat (2) step();
        check("rst_instr", 32'(instr_out), 32'd0);
        check("rst_ena", 32'(instr_ena), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(prog_count), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_ready", 32'(host_ready), 32'd0);
        rst = 1'b0;
        step();
        check("ready_after_rst", 32'(host_ready), 32'd1);

        // Basic three-instruction program
        prog = '{16'h1105, 16'h1203, 16'h2312};
        load_prog();
        check("basic_count", 32'(prog_count), 32'd3);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h08);
        run_check(3);
        repeat (3) step();
        check("basic_drained", 32'(res_valid), 32'd0);
        check("basic_sb", 32'(exp_q.size()), 32'd0);

        // Start with an empty program
        pulse_clear();
        check("clear_count", 32'(prog_count), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("empty_done", 32'(done), 32'd1);
        check("empty_ena", 32'(instr_ena), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);
        step();
        check("empty_done_off", 32'(done), 32'd0);
        check("empty_ready", 32'(host_ready), 32'd1);

        // Full program buffer
        pulse_clear();
        prog = '{16'h1103, 16'h120A, 16'h2312, 16'h3421,
                 16'h4512, 16'h5612, 16'h7712, 16'h0000};
        load_prog();
        check("full_count", 32'(prog_count), 32'd8);
        check("full_ready", 32'(host_ready), 32'd0);
        host_valid = 1'b1;
        host_data  = 8'h55;
        step();
        host_valid = 1'b0;
        check("full_no_accept", 32'(prog_count), 32'd8);
        ref_push(8);
        run_check(8);
        repeat (3) step();
        check("full_drained", 32'(res_valid), 32'd0);

        // Start ignored while results are still pending
        res_ready = 1'b0;
        ref_push(8);
        run_check(8);
        check("held_valid", 32'(res_valid), 32'd1);
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        check("held_busy", 32'(busy), 32'd0);
        check("held_ena", 32'(instr_ena), 32'd0);
        step();
        check("held_busy2", 32'(busy), 32'd0);
        res_ready = 1'b1;
        repeat (10) step();
        check("held_drained", 32'(res_valid), 32'd0);
        check("held_sb", 32'(exp_q.size()), 32'd0);
        check("held_no_done", 32'(done_cnt - d0), 32'd0);

        // Abort during ISSUE
        pulse_clear();
        prog = '{16'h1101, 16'h1202, 16'h2312, 16'h7312, 16'h6430};
        load_prog();
        check("abort_count", 32'(prog_count), 32'd5);
        res_ready = 1'b0;
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        check("abort_i0", 32'(instr_out), 32'(prog[0]));
        step();
        check("abort_i1", 32'(instr_out), 32'(prog[1]));
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("abort_ena", 32'(instr_ena), 32'd0);
        check("abort_valid", 32'(res_valid), 32'd0);
        check("abort_count0", 32'(prog_count), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (6) step();
        check("abort_valid_late", 32'(res_valid), 32'd0);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        res_ready = 1'b1;

        // Partial byte discarded on start, re-run reproduces results
        prog = '{16'h1409, 16'h6B40};
        load_prog();
        host_valid = 1'b1;
        host_data  = 8'h2A;
        step();
        host_valid = 1'b0;
        check("partial_count", 32'(prog_count), 32'd2);
        ref_push(2);
        run_check(2);
        repeat (3) step();
        check("partial_drained", 32'(res_valid), 32'd0);
        ref_push(2);
        run_check(2);
        repeat (3) step();
        check("rerun_sb", 32'(exp_q.size()), 32'd0);
        prog.push_back(16'h1377);
        load_word(16'h1377);
        check("append_count", 32'(prog_count), 32'd3);
        ref_push(3);
        run_check(3);
        repeat (3) step();

        // Asynchronous reset in DRAIN
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("drain_busy_pre", 32'(busy), 32'd1);
        check("drain_ena_pre", 32'(instr_ena), 32'd0);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_instr", 32'(instr_out), 32'd0);
        check("arst_ena", 32'(instr_ena), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_count", 32'(prog_count), 32'd0);
        check("arst_valid", 32'(res_valid), 32'd0);
        check("arst_ready", 32'(host_ready), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(host_ready), 32'd1);
        check("post_rst_count", 32'(prog_count), 32'd0);
        check("post_rst_valid", 32'(res_valid), 32'd0);
        check("final_sb", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_issue_sequencer.md
Name: instr_issue_sequencer

Overview:
- Host-side driver for the 8-bit register compute unit.
- Receives a program of 16-bit instructions as a host byte stream and stores it.
- On `start`, issues the program back-to-back on the compute unit's 16-bit instruction bus with `ena`.
- Captures each 8-bit result returned after a fixed latency into a result FIFO that the host drains.

Parameters:
- `DEPTH`, 8: program buffer and result FIFO capacity, in instructions. Power of two, at least 2.
- `RESULT_LATENCY`, 2: cycles from an instruction being presented with `ena` to its result being valid on `result_in`. At least 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `host_valid`  in  1  host byte valid.
- `host_data`  in  8  host program byte.
- `host_ready`  out  1  sequencer accepts a byte this cycle.
- `start`  in  1  single-cycle pulse: run the stored program.
- `clear`  in  1  single-cycle pulse: abort, empty both buffers.
- `instr_out`  out  16  instruction to compute unit; [15:8] drives ui_in, [7:0] drives uio_in.
- `instr_ena`  out  1  drives compute unit `ena`.
- `result_in`  in  8  compute unit uo_out.
- `res_valid`  out  1  result FIFO not empty.
- `res_data`  out  8  result FIFO head (show-ahead).
- `res_ready`  in  1  host pops the head.
- `busy`  out  1  state is ISSUE or DRAIN.
- `done`  out  1  one-cycle pulse at run completion.
- `prog_count`  out  $clog2(DEPTH)+1  number of instructions stored.

Behaviour:
- Reset (async, immediate), all registered state cleared:
  - state = IDLE; `instr_out` = 0, `instr_ena` = 0, `done` = 0, `busy` = 0, `prog_count` = 0.
  - Result FIFO is empty, so `res_valid` = 0. Partial-byte latch is cleared.
  - `host_ready` is combinational and is 0 while `rst` is high.
- States:
  - IDLE → ISSUE → DRAIN → DONE → IDLE.
  - `clear` in any state: next state is IDLE, both buffers are emptied, the partial byte and the latency pipe are discarded, and `instr_ena` is 0 on the next cycle.
- Loading:
  - `host_ready` = (state == IDLE) && (`prog_count` < `DEPTH`) && !`rst`.
  - A byte is accepted when `host_valid` && `host_ready`.
  - The first byte is the high byte (opcode/target). The second byte is the low byte.
  - The word is written at index `prog_count` on the second byte, and `prog_count` increments on that edge.
  - Bytes are not accepted outside IDLE.
- Start (evaluated only in IDLE with `clear` low):
  - If the result FIFO is not empty, `start` is ignored.
  - If `prog_count` == 0, `done` pulses the next cycle and the state stays IDLE.
  - Otherwise the partial byte is discarded and the state goes to ISSUE.
  - `start` outside IDLE is ignored.
- ISSUE:
  - With `start` at cycle t, instruction k (0..N-1) is registered onto `instr_out` with `instr_ena` = 1 in cycle t+1+k.
  - After the last instruction the state goes to DRAIN, and `instr_out` = 0, `instr_ena` = 0.
- Capture:
  - A valid-flag shift pipe of `RESULT_LATENCY` stages is fed by `instr_ena`.
  - When a flag exits the pipe, `result_in` is pushed into the result FIFO.
  - The result of instruction k is sampled at the end of cycle t+1+k+`RESULT_LATENCY`.
  - Results are captured for every instruction, including NOPs, which return 0.
- DRAIN: lasts until the pipe is empty, then goes to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
  - `done` cycle for N instructions = t+2+N+`RESULT_LATENCY`.
  - The program is retained, so a new `start` re-runs it.
- Result FIFO:
  - Cannot overflow: start requires an empty FIFO and a run produces at most `DEPTH` results.
  - Push and pop in the same cycle are allowed; occupancy stays unchanged.
  - Pop while empty is ignored.
  - Host pops are allowed in any state.
- Widths: all counters wrap-free by construction. `prog_count` saturates at `DEPTH` because `host_ready` drops.

Decomposition:
- Package `issue_seq_pkg`:
  - state enum (IDLE, ISSUE, DRAIN, DONE);
  - byte-order constant (high byte first);
  - opcode constants NOP, LOAD, ADD, SUB, AND, OR, NOT, XOR = 0–7 for bench and program use.
- Sub-module `byte_fifo`: synchronous show-ahead FIFO, parameter `DEPTH`, width 8, with async active-high reset. It is used for the result buffer. The program buffer is a local indexed array.

Test Plan:
- Bench setup: DUT is connected to a behavioural compute-unit model with latency 2.
- Basic program: load bytes 11,05,12,03,23,12 (three instructions) → `prog_count` = 3, then pulse `start`.
  - Required response: `instr_out` = 0x1105, 0x1203, 0x2312 with `instr_ena` in three consecutive cycles.
  - Results popped in order: 05, 03, 08. `done` is one pulse 2+3+2 cycles after `start`.
- Full buffer: load 8 instructions → `host_ready` = 0 and `prog_count` = 8. A 17th byte with `host_valid` high is not accepted.
- Boundary starts:
  - `start` with `prog_count` = 0 → `done` next cycle, no `instr_ena`.
  - `start` while the result FIFO still holds a value → ignored, `busy` stays 0.
- Abort: `clear` during ISSUE after 2 of 5 instructions → `instr_ena` = 0 next cycle, `res_valid` = 0, `prog_count` = 0, no `done` pulse.
- Partial byte: load byte 0x2A only, then `start` with 2 stored instructions → the partial byte is discarded and exactly 2 instructions are issued. Re-`start` after draining the results reproduces identical results.
- Async reset mid-DRAIN: assert `rst` between clock edges → all outputs are 0 immediately. After release, `host_ready` = 1 and `prog_count` = 0.
